clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_pkg.sv | 19 +
 rtl/clk_gate_idle_cnt.sv | 43 ++++
 rtl/clk_gate_ctrl.sv | 156 +++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// ---------------------------------------------------------------------------
// clk_gate_pkg
// Shared definitions for the clock-gate controller: the 2-bit FSM state
// encoding and the default configuration constants used as parameter
// defaults by clk_gate_ctrl.
// ---------------------------------------------------------------------------
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_COUNT = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } gate_state_t;

    localparam int IDLE_W_DEF   = 8;
    localparam int WAKE_DLY_DEF = 2;

endpackage

// File: rtl/clk_gate_idle_cnt.sv
// ---------------------------------------------------------------------------
// clk_gate_idle_cnt
// Idle counter for the clock-gate controller. A load clears the count and
// captures the threshold; increments stop once the count equals the
// captured threshold, so the counter never wraps.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset (count and threshold to 0)
//   i_load    - clear count, capture i_thresh
//   i_inc     - advance count (ignored once o_hit is high)
//   i_thresh  - threshold to capture on i_load
//   o_hit     - count equals captured threshold
// ---------------------------------------------------------------------------
module clk_gate_idle_cnt #(
    parameter int IDLE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [IDLE_W-1:0] i_thresh,
    output logic              o_hit
);

    logic [IDLE_W-1:0] r_cnt;
    logic [IDLE_W-1:0] r_thresh;

    assign o_hit = (r_cnt == r_thresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_thresh <= '0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_thresh <= i_thresh;
        end else if (i_inc && !o_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
// Clock-gate controller. After idle_thresh+1 consecutive idle cycles in
// COUNT the gate enable is dropped (OFF). Any abort condition (busy,
// wake_req, force_on, !sleep_en) re-enables the gate; after WAKE_DLY
// settle cycles the FSM returns to ON, where a pending wake_req is
// acknowledged with a single-cycle pulse.
//
// Optional feature macro: CLK_GATE_CTRL_STAT_EN adds the gated_cycles
// output, a saturating count of cycles spent with sleeping high.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-high reset
//   sleep_en     - global permission to gate
//   force_on     - test/scan override, keeps the clock on
//   busy         - downstream activity
//   wake_req     - level wake request, held until wake_ack
//   idle_thresh  - idle cycles to wait before gating
//   gate_en      - registered enable to the clock-gate cell
//   wake_ack     - one-cycle pulse, clock running and settled
//   sleeping     - registered, high exactly while in OFF
//   gated_cycles - (CLK_GATE_CTRL_STAT_EN only) saturating sleep counter
// ---------------------------------------------------------------------------
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W   = IDLE_W_DEF,
    parameter int WAKE_DLY = WAKE_DLY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sleep_en,
    input  logic              force_on,
    input  logic              busy,
    input  logic              wake_req,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic              gate_en,
    output logic              wake_ack,
    output logic              sleeping
`ifdef CLK_GATE_CTRL_STAT_EN
    ,
    output logic [15:0]       gated_cycles
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(WAKE_DLY - 1);

    gate_state_t r_state;
    gate_state_t w_next;
    logic        r_gate_en;
    logic        r_sleeping;
    logic        r_ack;
    logic        r_ack_done;
    logic [3:0]  r_settle;
    logic        w_abort;
    logic        w_load;
    logic        w_inc;
    logic        w_hit;
    logic        w_ack_set;

    assign w_abort   = busy | wake_req | force_on | ~sleep_en;
    // r_ack_done remembers that the current request level was already
    // acknowledged, so a held request yields only one pulse.
    assign w_ack_set = (r_state == ST_ON) && wake_req && !r_ack && !r_ack_done;

    clk_gate_idle_cnt #(
        .IDLE_W (IDLE_W)
    ) u_idle_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_inc    (w_inc),
        .i_thresh (idle_thresh),
        .o_hit    (w_hit)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            ST_ON: begin
                if (!w_abort) begin
                    w_next = ST_COUNT;
                    w_load = 1'b1;
                end
            end
            ST_COUNT: begin
                // Abort takes priority over reaching the threshold.
                if (w_abort) begin
                    w_next = ST_ON;
                end else if (w_hit) begin
                    w_next = ST_OFF;
                end else begin
                    w_inc = 1'b1;
                end
            end
            ST_OFF: begin
                if (w_abort) begin
                    w_next = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_next = ST_ON;
                end
            end
            default: w_next = ST_ON;
        endcase
    end

    // Gate enable and sleeping are decoded from the next state and
    // registered, so they flip on the same edge as the state change and
    // have no combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ON;
            r_gate_en  <= 1'b1;
            r_sleeping <= 1'b0;
            r_ack      <= 1'b0;
            r_ack_done <= 1'b0;
            r_settle   <= '0;
        end else begin
            r_state    <= w_next;
            r_gate_en  <= (w_next != ST_OFF);
            r_sleeping <= (w_next == ST_OFF);
            r_ack      <= w_ack_set;
            if (!wake_req) begin
                r_ack_done <= 1'b0;
            end else if (w_ack_set) begin
                r_ack_done <= 1'b1;
            end
            r_settle   <= (r_state == ST_WAKE) ? (r_settle + 4'd1) : 4'd0;
        end
    end

    assign gate_en  = r_gate_en;
    assign wake_ack = r_ack;
    assign sleeping = r_sleeping;

`ifdef CLK_GATE_CTRL_STAT_EN
    logic [15:0] r_gated_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gated_cycles <= '0;
        end else if (r_sleeping && (r_gated_cycles != 16'hFFFF)) begin
            r_gated_cycles <= r_gated_cycles + 16'd1;
        end
    end

    assign gated_cycles = r_gated_cycles;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       sleep_en;
    logic       force_on;
    logic       busy;
    logic       wake_req;
    logic [7:0] idle_thresh;
    logic       gate_en;
    logic       wake_ack;
    logic       sleeping;
`ifdef CLK_GATE_CTRL_STAT_EN
    logic [15:0] gated_cycles;
`endif

    int total;
    int bad;

    clk_gate_ctrl #(
        .IDLE_W   (8),
        .WAKE_DLY (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sleep_en     (sleep_en),
        .force_on     (force_on),
        .busy         (busy),
        .wake_req     (wake_req),
        .idle_thresh  (idle_thresh),
        .gate_en      (gate_en),
        .wake_ack     (wake_ack),
        .sleeping     (sleeping)
`ifdef CLK_GATE_CTRL_STAT_EN
        ,
        .gated_cycles (gated_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sleep_en = 1'b1; force_on = 1'b0; busy = 1'b1;
        wake_req = 1'b0; idle_thresh = 8'd0;
        step(); step();
        total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL reset_gate_en got=%b exp=1", gate_en); end
        total++; if (sleeping !== 1'b0) begin bad++; $display("FAIL reset_sleeping got=%b exp=0", sleeping); end
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL reset_wake_ack got=%b exp=0", wake_ack); end
        rst = 1'b0;
        step();
        total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL post_reset_gate_en got=%b exp=1", gate_en); end
    endtask

    // Idle observed in ON at cycle t, thresh=3: gate_en low from t+5.
    task automatic test_sleep_entry();
        idle_thresh = 8'd3;
        busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL entry_gate_on t+%0d got=%b exp=1", i, gate_en); end
            total++; if (sleeping !== 1'b0) begin bad++; $display("FAIL entry_sleep_off t+%0d got=%b exp=0", i, sleeping); end
        end
        step();
        total++; if (gate_en !== 1'b0) begin bad++; $display("FAIL entry_gate_off got=%b exp=0", gate_en); end
        total++; if (sleeping !== 1'b1) begin bad++; $display("FAIL entry_sleeping got=%b exp=1", sleeping); end
        step();
        total++; if (gate_en !== 1'b0) begin bad++; $display("FAIL entry_hold_off got=%b exp=0", gate_en); end
    endtask

    // From OFF: wake_req at w -> gate_en w+1, ON w+3, ack at w+4 only.
    task automatic test_wake();
        wake_req = 1'b1;
        step();
        total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL wake_gate_on got=%b exp=1", gate_en); end
        total++; if (sleeping !== 1'b0) begin bad++; $display("FAIL wake_sleep_off got=%b exp=0", sleeping); end
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL wake_ack_w1 got=%b exp=0", wake_ack); end
        step();
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL wake_ack_w2 got=%b exp=0", wake_ack); end
        step();
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL wake_ack_w3 got=%b exp=0", wake_ack); end
        step();
        total++; if (wake_ack !== 1'b1) begin bad++; $display("FAIL wake_ack_w4 got=%b exp=1", wake_ack); end
        for (int i = 5; i <= 8; i++) begin
            step();
            total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL wake_ack_held w+%0d got=%b exp=0", i, wake_ack); end
        end
        busy = 1'b1;
        wake_req = 1'b0;
        step();
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL wake_ack_dropped got=%b exp=0", wake_ack); end
        wake_req = 1'b1;
        step();
        total++; if (wake_ack !== 1'b1) begin bad++; $display("FAIL wake_ack_reissue got=%b exp=1", wake_ack); end
        wake_req = 1'b0;
        step();
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL wake_ack_reissue_end got=%b exp=0", wake_ack); end
    endtask

    // thresh=5, busy pulse at count 4 -> ON; mid-COUNT thresh change ignored.
    task automatic test_abort_restart();
        busy = 1'b1;
        step();
        idle_thresh = 8'd5;
        busy = 1'b0;
        step();
        idle_thresh = 8'd0;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL abort_count cnt=%0d got=%b exp=1", i, gate_en); end
        end
        busy = 1'b1;
        idle_thresh = 8'd5;
        step();
        total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL abort_to_on got=%b exp=1", gate_en); end
        busy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL restart_on u+%0d got=%b exp=1", i, gate_en); end
        end
        step();
        total++; if (gate_en !== 1'b0) begin bad++; $display("FAIL restart_off u+7 got=%b exp=0", gate_en); end
        busy = 1'b1;
        step(); step(); step();
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL busy_wake_no_ack got=%b exp=0", wake_ack); end
    endtask

    // thresh=0: abort on the hit cycle wins; without abort gate off at t+2.
    task automatic test_abort_wins();
        idle_thresh = 8'd0;
        busy = 1'b0;
        step();
        busy = 1'b1;
        step();
        total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL tie_gate got=%b exp=1", gate_en); end
        total++; if (sleeping !== 1'b0) begin bad++; $display("FAIL tie_sleeping got=%b exp=0", sleeping); end
        busy = 1'b0;
        step();
        total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL thr0_t1 got=%b exp=1", gate_en); end
        step();
        total++; if (gate_en !== 1'b0) begin bad++; $display("FAIL thr0_t2 got=%b exp=0", gate_en); end
        busy = 1'b1;
        step(); step(); step();
    endtask

    task automatic test_force_on();
        force_on = 1'b1;
        sleep_en = 1'b1;
        busy = 1'b0;
        idle_thresh = 8'd0;
        for (int i = 0; i < 100; i++) begin
            step();
            total++; if (gate_en !== 1'b1 || sleeping !== 1'b0) begin
                bad++; $display("FAIL force_on cyc=%0d gate_en=%b sleeping=%b exp=1/0", i, gate_en, sleeping);
            end
        end
        force_on = 1'b0;
        sleep_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL no_sleep_en cyc=%0d got=%b exp=1", i, gate_en); end
        end
        sleep_en = 1'b1;
        busy = 1'b1;
        step();
    endtask

    task automatic test_reset_in_off();
        idle_thresh = 8'd0;
        busy = 1'b0;
        step(); step();
        total++; if (sleeping !== 1'b1) begin bad++; $display("FAIL rst_off_pre got=%b exp=1", sleeping); end
        rst = 1'b1;
        wake_req = 1'b1;
        step();
        total++; if (gate_en !== 1'b1) begin bad++; $display("FAIL rst_off_gate got=%b exp=1", gate_en); end
        total++; if (sleeping !== 1'b0) begin bad++; $display("FAIL rst_off_sleeping got=%b exp=0", sleeping); end
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL rst_off_ack1 got=%b exp=0", wake_ack); end
        step();
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL rst_off_ack2 got=%b exp=0", wake_ack); end
        rst = 1'b0;
        step();
        total++; if (wake_ack !== 1'b1) begin bad++; $display("FAIL rst_release_ack got=%b exp=1", wake_ack); end
        wake_req = 1'b0;
        busy = 1'b1;
        step();
        total++; if (wake_ack !== 1'b0) begin bad++; $display("FAIL rst_release_ack_end got=%b exp=0", wake_ack); end
    endtask

`ifdef CLK_GATE_CTRL_STAT_EN
    task automatic test_stat();
        rst = 1'b1;
        busy = 1'b1;
        step();
        rst = 1'b0;
        total++; if (gated_cycles !== 16'd0) begin bad++; $display("FAIL stat_reset got=%h exp=0000", gated_cycles); end
        idle_thresh = 8'd0;
        busy = 1'b0;
        step(); step();
        total++; if (gated_cycles !== 16'd0) begin bad++; $display("FAIL stat_start got=%h exp=0000", gated_cycles); end
        repeat (10) step();
        total++; if (gated_cycles !== 16'd10) begin bad++; $display("FAIL stat_10 got=%h exp=000a", gated_cycles); end
        repeat (70000) step();
        total++; if (gated_cycles !== 16'hFFFF) begin bad++; $display("FAIL stat_sat got=%h exp=ffff", gated_cycles); end
        total++; if (sleeping !== 1'b1) begin bad++; $display("FAIL stat_sleeping got=%b exp=1", sleeping); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sleep_entry();
        test_wake();
        test_abort_restart();
        test_abort_wins();
        test_force_on();
        test_reset_in_off();
`ifdef CLK_GATE_CTRL_STAT_EN
        test_stat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
